// File: rtl/demod_pkg.sv
// Shared definitions for the QPSK demodulator lock supervisor.
package demod_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESYNC = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SEARCH = 3'd3,
        ST_VERIFY = 3'd4,
        ST_LOCKED = 3'd5
    } state_t;

    localparam int FRAME_BITS = 40;
    localparam int TMR_W      = 16;
    localparam int CNT_W      = 8;

    // |v| with the single unrepresentable value -32768 clamped to 32767
    function automatic logic [15:0] abs_sat16(input logic signed [15:0] v);
        if (v == 16'sh8000)
            return 16'h7FFF;
        else if (v[15])
            return ~v + 16'd1;
        else
            return v;
    endfunction

endpackage

// File: rtl/pe_monitor.sv
// Phase-error supervisor: counts consecutive over-threshold symbol decisions
// while active and raises pe_loss once the run length reaches PE_MAX.
module pe_monitor
    import demod_pkg::*;
#(
    parameter int PE_THRESH = 4096,
    parameter int PE_MAX    = 40
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               active,
    input  logic               sync_flag,
    input  logic signed [15:0] phase_error,
    output logic               pe_loss
);

    logic [15:0]      mag;
    logic             over;
    logic [CNT_W-1:0] pe_cnt_q;
    logic [CNT_W-1:0] pe_cnt_d;

    always_comb begin
        mag      = abs_sat16(phase_error);
        over     = (mag > 16'(PE_THRESH));
        pe_cnt_d = pe_cnt_q;
        if (!active)
            pe_cnt_d = '0;
        else if (sync_flag) begin
            if (!over)
                pe_cnt_d = '0;
            else if (pe_cnt_q != CNT_W'(PE_MAX))
                pe_cnt_d = pe_cnt_q + 1'b1;
        end
        // reflects the count including the current sample, so the FSM leaves on the next edge
        pe_loss = active && (pe_cnt_d == CNT_W'(PE_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pe_cnt_q <= '0;
        else
            pe_cnt_q <= pe_cnt_d;
    end

endmodule

// File: rtl/demod_lock_ctrl.sv
// Acquisition and lock supervisor for the QPSK demodulator datapath.
//   state  | meaning
//   IDLE   | disabled, datapath held in reset
//   RESYNC | datapath reset pulse of RST_CYC cycles
//   SETTLE | filter/DDS settling, flags ignored
//   SEARCH | waiting for first good frame
//   VERIFY | counting consecutive good frames
//   LOCKED | forwarding frames, watching misses and phase error
module demod_lock_ctrl
    import demod_pkg::*;
#(
    parameter int RST_CYC    = 16,
    parameter int SETTLE_CYC = 2000,
    parameter int FRAME_WIN  = 2200,
    parameter int SEARCH_TO  = 8000,
    parameter int LOCK_CNT   = 3,
    parameter int MISS_MAX   = 2,
    parameter int PE_THRESH  = 4096,
    parameter int PE_MAX     = 40
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  header_flag,
    input  logic                  valid_flag,
    input  logic                  sync_flag,
    input  logic signed [15:0]    phase_error,
    input  logic [FRAME_BITS-1:0] data_in,
    output logic                  dp_rst,
    output logic                  locked,
    output logic [FRAME_BITS-1:0] data_out,
    output logic                  data_valid,
    output logic [2:0]            state,
    output logic [15:0]           frame_cnt,
    output logic [7:0]            resync_cnt
);

    state_t                state_q, state_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [CNT_W-1:0]      good_q, good_d;
    logic [CNT_W-1:0]      miss_q, miss_d;
    logic                  dp_rst_q, dp_rst_d;
    logic                  locked_q, locked_d;
    logic [FRAME_BITS-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic [7:0]            resync_cnt_q, resync_cnt_d;

    logic pe_active;
    logic pe_loss;
    logic win_hit;
    logic miss_loss;
    logic loss;
    logic fwd;

    assign pe_active = (state_q == ST_LOCKED);
    assign win_hit   = (timer_q == TMR_W'(FRAME_WIN - 1));
    // miss loss is judged without regard to valid_flag so it beats a frame on the same cycle
    assign miss_loss = pe_active && win_hit && ((miss_q + 1'b1) == CNT_W'(MISS_MAX));
    assign loss      = miss_loss || pe_loss;

    pe_monitor #(
        .PE_THRESH (PE_THRESH),
        .PE_MAX    (PE_MAX)
    ) u_pe_monitor (
        .clk         (clk),
        .rst         (rst),
        .active      (pe_active),
        .sync_flag   (sync_flag),
        .phase_error (phase_error),
        .pe_loss     (pe_loss)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            good_q       <= '0;
            miss_q       <= '0;
            dp_rst_q     <= 1'b1;
            locked_q     <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_cnt_q  <= '0;
            resync_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            good_q       <= good_d;
            miss_q       <= miss_d;
            dp_rst_q     <= dp_rst_d;
            locked_q     <= locked_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_cnt_q  <= frame_cnt_d;
            resync_cnt_q <= resync_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        good_d  = good_q;
        miss_d  = miss_q;
        case (state_q)
            ST_IDLE: begin
                if (enable)
                    state_d = ST_RESYNC;
            end
            ST_RESYNC: begin
                if (timer_q == TMR_W'(RST_CYC - 1))
                    state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (timer_q == TMR_W'(SETTLE_CYC - 1))
                    state_d = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (valid_flag) begin
                    state_d = ST_VERIFY;
                    good_d  = CNT_W'(1);
                end else if (timer_q == TMR_W'(SEARCH_TO - 1))
                    state_d = ST_RESYNC;
                else if (header_flag)
                    timer_d = '0;
            end
            ST_VERIFY: begin
                if (valid_flag) begin
                    good_d  = good_q + 1'b1;
                    timer_d = '0;
                    if (good_d == CNT_W'(LOCK_CNT))
                        state_d = ST_LOCKED;
                end else if (win_hit) begin
                    state_d = ST_SEARCH;
                    good_d  = '0;
                end else if (header_flag)
                    timer_d = '0;
            end
            ST_LOCKED: begin
                if (loss)
                    state_d = ST_RESYNC;
                else if (valid_flag) begin
                    timer_d = '0;
                    miss_d  = '0;
                end else if (win_hit) begin
                    timer_d = '0;
                    miss_d  = miss_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!enable)
            state_d = ST_IDLE;
        if (state_d != state_q)
            timer_d = '0;
        if (state_d != ST_VERIFY)
            good_d = '0;
        if (state_d != ST_LOCKED)
            miss_d = '0;
    end

    always_comb begin
        fwd          = enable && (state_q == ST_LOCKED) && valid_flag && !loss;
        dp_rst_d     = (state_d == ST_IDLE) || (state_d == ST_RESYNC);
        locked_d     = (state_d == ST_LOCKED);
        data_valid_d = fwd;
        data_out_d   = fwd ? data_in : data_out_q;
        frame_cnt_d  = fwd ? frame_cnt_q + 16'd1 : frame_cnt_q;
        resync_cnt_d = resync_cnt_q;
        if ((state_d == ST_RESYNC) && (state_q != ST_RESYNC) && (state_q != ST_IDLE) &&
            (resync_cnt_q != 8'hFF))
            resync_cnt_d = resync_cnt_q + 8'd1;
    end

    assign dp_rst     = dp_rst_q;
    assign locked     = locked_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign state      = state_q;
    assign frame_cnt  = frame_cnt_q;
    assign resync_cnt = resync_cnt_q;

endmodule

// File: tb/tb_demod_lock_ctrl.sv
// Directed bench for demod_lock_ctrl with shortened settle/window/timeout values.
`timescale 1ns/1ps
module tb_demod_lock_ctrl;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic               header_flag = 1'b0;
    logic               valid_flag = 1'b0;
    logic               sync_flag = 1'b0;
    logic signed [15:0] phase_error = 16'sd0;
    logic [39:0]        data_in = 40'h0;
    logic               dp_rst;
    logic               locked;
    logic [39:0]        data_out;
    logic               data_valid;
    logic [2:0]         state;
    logic [15:0]        frame_cnt;
    logic [7:0]         resync_cnt;

    int          checks = 0;
    int          errors = 0;
    int          dv_count = 0;
    int          exp_frames = 0;
    int          exp_resync = 0;
    logic [39:0] exp_data = 40'h0;

    typedef struct {
        logic signed [15:0] pe;
        logic               loss;
    } pe_vec_t;
    pe_vec_t vecs [8];

    demod_lock_ctrl #(
        .SETTLE_CYC (20),
        .FRAME_WIN  (220),
        .SEARCH_TO  (800)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .header_flag (header_flag),
        .valid_flag  (valid_flag),
        .sync_flag   (sync_flag),
        .phase_error (phase_error),
        .data_in     (data_in),
        .dp_rst      (dp_rst),
        .locked      (locked),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .state       (state),
        .frame_cnt   (frame_cnt),
        .resync_cnt  (resync_cnt)
    );

    always #1000 clk = ~clk;

    initial begin
        #(64'd2000 * 64'd60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (data_valid) dv_count++;
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound, input string name);
        int n = 0;
        while (state !== s && n < bound) begin
            step();
            n++;
        end
        chk(name, {61'd0, state}, {61'd0, s});
    endtask

    task automatic pulse_valid(input logic [39:0] d);
        valid_flag = 1'b1;
        data_in    = d;
        step();
        valid_flag = 1'b0;
    endtask

    task automatic pulse_fwd(input logic [39:0] d, input string name);
        pulse_valid(d);
        exp_frames++;
        exp_data = d;
        chk({name, "_dv"}, 64'(data_valid), 64'd1);
        chk({name, "_data"}, 64'(data_out), 64'(exp_data));
        chk({name, "_frames"}, 64'(frame_cnt), 64'(exp_frames));
    endtask

    task automatic acquire();
        int dv0;
        wait_state(3'd3, 3000, "acq_search");
        dv0 = dv_count;
        pulse_valid(40'h11_1111_1111);
        step(199);
        pulse_valid(40'h22_2222_2222);
        chk("acq_not_yet_locked", 64'(locked), 64'd0);
        step(199);
        pulse_valid(40'h33_3333_3333);
        chk("acq_locked", 64'(locked), 64'd1);
        chk("acq_state", 64'(state), 64'd5);
        chk("acq_no_dv", 64'(dv_count - dv0), 64'd0);
        chk("acq_data_hold", 64'(data_out), 64'(exp_data));
    endtask

    task automatic sync_seq(input int n1, input logic signed [15:0] v, input int n2);
        sync_flag   = 1'b1;
        phase_error = 16'sd0;
        step();
        for (int i = 0; i < n1; i++) begin
            phase_error = 16'sh8000;
            step();
        end
        phase_error = v;
        step();
        for (int i = 0; i < n2; i++) begin
            phase_error = 16'sh8000;
            step();
        end
        sync_flag   = 1'b0;
        phase_error = 16'sd0;
    endtask

    initial begin
        int dp_hi;

        vecs[0] = '{16'sh8000,   1'b1};
        vecs[1] = '{16'sd100,    1'b0};
        vecs[2] = '{16'sd4096,   1'b0};
        vecs[3] = '{16'sd4097,   1'b1};
        vecs[4] = '{-16'sd4096,  1'b0};
        vecs[5] = '{-16'sd4097,  1'b1};
        vecs[6] = '{16'sd32767,  1'b1};
        vecs[7] = '{16'sd0,      1'b0};

        // reset values
        step(3);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_dp_rst", 64'(dp_rst), 64'd1);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_data_valid", 64'(data_valid), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_resync_cnt", 64'(resync_cnt), 64'd0);

        // start-up sequence: 16 reset cycles, 20 settle cycles, SEARCH at edge 37
        rst    = 1'b0;
        enable = 1'b1;
        dp_hi  = 0;
        for (int i = 1; i <= 37; i++) begin
            step();
            if (dp_rst) dp_hi++;
            if (i == 1)  chk("t1_resync_entry", 64'(state), 64'd1);
            if (i == 16) chk("t1_resync_last", 64'(state), 64'd1);
            if (i == 17) chk("t1_settle_entry", 64'(state), 64'd2);
            if (i == 36) chk("t1_settle_last", 64'(state), 64'd2);
        end
        chk("t1_dp_rst_cycles", 64'(dp_hi), 64'd16);
        chk("t1_search", 64'(state), 64'd3);
        chk("t1_resync_cnt", 64'(resync_cnt), 64'd0);

        // lock on three frames 200 cycles apart
        pulse_valid(40'hAA_0000_0001);
        chk("t2_verify", 64'(state), 64'd4);
        step(199);
        pulse_valid(40'hAA_0000_0002);
        chk("t2_verify2", 64'(state), 64'd4);
        chk("t2_not_locked", 64'(locked), 64'd0);
        step(199);
        pulse_valid(40'hAA_0000_0003);
        chk("t2_locked", 64'(locked), 64'd1);
        chk("t2_state", 64'(state), 64'd5);
        chk("t2_no_dv", 64'(dv_count), 64'd0);
        chk("t2_data_out", 64'(data_out), 64'd0);

        // first forwarded frame
        pulse_fwd(40'hCC_1234_5678, "t3");
        step();
        chk("t3_dv_drop", 64'(data_valid), 64'd0);
        chk("t3_dv_once", 64'(dv_count), 64'd1);

        // 40 bad symbols but one clean sample at symbol 39: stays locked
        sync_seq(38, 16'sd100, 1);
        chk("t5_stay_state", 64'(state), 64'd5);
        chk("t5_stay_locked", 64'(locked), 64'd1);

        // threshold table: 39 saturated samples followed by the sample under test
        for (int i = 0; i < 8; i++) begin
            if (state !== 3'd5) acquire();
            pulse_fwd(40'hA0_0000_0000 + 40'(i), "pe_fwd");
            sync_seq(39, vecs[i].pe, 0);
            if (vecs[i].loss) exp_resync++;
            chk("pe_state", 64'(state), vecs[i].loss ? 64'd1 : 64'd5);
            chk("pe_resync_cnt", 64'(resync_cnt), 64'(exp_resync));
        end

        // frame on the window-expiry cycle counts as no miss; then two misses lose lock
        if (state !== 3'd5) acquire();
        pulse_fwd(40'hBB_0000_0001, "t4_fwd_a");
        step(219);
        pulse_fwd(40'hBB_0000_0002, "t4_fwd_expiry");
        step(439);
        chk("t4_still_locked", 64'(state), 64'd5);
        step();
        exp_resync++;
        chk("t4_resync", 64'(state), 64'd1);
        chk("t4_locked", 64'(locked), 64'd0);
        chk("t4_dp_rst", 64'(dp_rst), 64'd1);
        chk("t4_resync_cnt", 64'(resync_cnt), 64'(exp_resync));

        // SEARCH timeout
        wait_state(3'd3, 100, "t6_search");
        step(799);
        chk("t6_search_last", 64'(state), 64'd3);
        step();
        exp_resync++;
        chk("t6_timeout", 64'(state), 64'd1);
        chk("t6_resync_cnt", 64'(resync_cnt), 64'(exp_resync));

        // frame on the miss-loss cycle is dropped
        acquire();
        pulse_fwd(40'hCD_0000_0001, "t6c_fwd");
        step(439);
        valid_flag = 1'b1;
        data_in    = 40'hDE_ADBE_EF01;
        step();
        valid_flag = 1'b0;
        exp_resync++;
        chk("t6c_state", 64'(state), 64'd1);
        chk("t6c_no_dv", 64'(data_valid), 64'd0);
        chk("t6c_frames", 64'(frame_cnt), 64'(exp_frames));
        chk("t6c_data_hold", 64'(data_out), 64'(exp_data));
        chk("t6c_resync_cnt", 64'(resync_cnt), 64'(exp_resync));

        // enable drop from RESYNC, SETTLE, SEARCH, VERIFY
        for (int t = 1; t <= 4; t++) begin
            enable = 1'b0;
            step();
            chk("drop_pre_idle", 64'(state), 64'd0);
            enable = 1'b1;
            wait_state((t == 4) ? 3'd3 : 3'(t), 100, "drop_reach");
            if (t == 4) begin
                pulse_valid(40'h00_0000_0005);
                chk("drop_verify", 64'(state), 64'd4);
            end
            enable = 1'b0;
            step();
            chk("drop_idle", 64'(state), 64'd0);
            chk("drop_dp_rst", 64'(dp_rst), 64'd1);
        end
        chk("drop_resync_cnt", 64'(resync_cnt), 64'(exp_resync));

        // enable drop while locked
        enable = 1'b1;
        acquire();
        enable = 1'b0;
        step();
        chk("drop_lk_state", 64'(state), 64'd0);
        chk("drop_lk_locked", 64'(locked), 64'd0);
        chk("drop_lk_dp_rst", 64'(dp_rst), 64'd1);
        chk("drop_lk_data", 64'(data_out), 64'(exp_data));
        chk("drop_lk_dv", 64'(data_valid), 64'd0);

        // asynchronous reset mid-frame
        enable = 1'b1;
        acquire();
        pulse_fwd(40'h77_7777_7777, "ar_fwd");
        step(50);
        #500;
        rst = 1'b1;
        #1;
        chk("ar_state", 64'(state), 64'd0);
        chk("ar_dp_rst", 64'(dp_rst), 64'd1);
        chk("ar_locked", 64'(locked), 64'd0);
        chk("ar_data_out", 64'(data_out), 64'd0);
        chk("ar_frames", 64'(frame_cnt), 64'd0);
        chk("ar_resync_cnt", 64'(resync_cnt), 64'd0);
        step(2);
        rst = 1'b0;
        step();
        chk("ar_restart", 64'(state), 64'd1);
        chk("ar_restart_cnt", 64'(resync_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demod_lock_ctrl.md
# demod_lock_ctrl

Acquisition and lock supervisor for the QPSK demodulator, clocked in the 500 kHz sample domain. It sequences the datapath through reset, settle, frame search, verify and locked states, and watches frame-check pulses and phase error. On loss of lock it pulses a datapath reset. Only frames received while locked are forwarded, as a registered 40-bit word with a one-cycle valid strobe.

## Interface
- RST_CYC, 16: cycles `dp_rst` is held in RESYNC.
- SETTLE_CYC, 2000: cycles allowed for the filter and DDS to settle after a datapath reset.
- FRAME_WIN, 2200: maximum cycles between successive `valid_flag` pulses (nominal frame is 2000).
- SEARCH_TO, 8000: SEARCH timeout in cycles.
- LOCK_CNT, 3: consecutive good frames required to declare lock.
- MISS_MAX, 2: consecutive missed frames that declare lock lost.
- PE_THRESH, 4096: phase-error magnitude threshold.
- PE_MAX, 40: consecutive over-threshold symbols that declare lock lost.
- clk  in  1  500 kHz sample clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  run request; low forces IDLE
- header_flag  in  1  one-cycle pulse, frame header detected
- valid_flag  in  1  one-cycle pulse, header and checksum correct
- sync_flag  in  1  one-cycle pulse, symbol decision instant
- phase_error  in  16  signed phase error from the phase detector
- data_in  in  40  parallel frame from the frame checker
- dp_rst  out  1  registered active-high datapath reset
- locked  out  1  registered lock indication
- data_out  out  40  last forwarded frame
- data_valid  out  1  one-cycle strobe accompanying `data_out`
- state  out  3  current state encoding
- frame_cnt  out  16  forwarded frames, wraps
- resync_cnt  out  8  RESYNC entries, saturates at 255

## Operation
- States and encodings: IDLE=0, RESYNC=1, SETTLE=2, SEARCH=3, VERIFY=4, LOCKED=5.
- One 16-bit timer is cleared on every state change.
- IDLE: `dp_rst`=1. Exit to RESYNC when `enable`=1.
- RESYNC: `dp_rst`=1 for RST_CYC cycles, then SETTLE. Entry increments `resync_cnt` (saturating), except entry from IDLE.
- SETTLE: `dp_rst`=0. All flags are ignored. After SETTLE_CYC cycles go to SEARCH.
- SEARCH:
  - `valid_flag` → VERIFY with good=1.
  - Timer reaching SEARCH_TO-1 → RESYNC.
- VERIFY:
  - `valid_flag` → good+1 and timer cleared. When good reaches LOCK_CNT → LOCKED.
  - Timer reaching FRAME_WIN-1 → SEARCH with good=0.
- LOCKED: `locked`=1.
  - `valid_flag` → capture `data_in` to `data_out`, pulse `data_valid`, increment `frame_cnt`, clear timer, set miss=0.
  - Timer reaching FRAME_WIN-1 → miss+1 and timer cleared. When miss reaches MISS_MAX → RESYNC.
- Phase monitor (LOCKED only):
  - On `sync_flag`, compute |phase_error|; -32768 saturates to 32767.
  - If the magnitude is > PE_THRESH, pe+1; otherwise pe=0.
  - pe reaching PE_MAX → RESYNC.
  - pe is cleared outside LOCKED.
- `header_flag` only restarts the timer in SEARCH and VERIFY, so the window is measured from the header. It never changes state.
- Only frames whose `valid_flag` arrives while in LOCKED are forwarded. Frames received in VERIFY, including the one that completes lock, are not.
- Priorities within one cycle:
  - `enable`=0 overrides everything.
  - A loss condition (miss or pe) beats a `valid_flag` in the same cycle: the frame is not forwarded.
  - A `valid_flag` beats timer expiry in VERIFY and SEARCH.
  - In LOCKED, a `valid_flag` on the expiry cycle clears the timer with no miss.

## Timing
- Reset values: state=IDLE, `dp_rst`=1, `locked`=0, `data_out`=0, `data_valid`=0, `frame_cnt`=0, `resync_cnt`=0, all internal counters 0.
- All outputs are registered. State changes on the edge after the triggering input.
- `data_valid` and `data_out` update on the edge after `valid_flag`, giving 1-cycle latency.
- `locked` rises on the edge after the LOCK_CNT-th `valid_flag`. It falls on the same edge that enters RESYNC or IDLE.
- `dp_rst` rises on the edge that enters RESYNC/IDLE and falls on the edge that enters SETTLE.
- `enable` falling mid-operation: IDLE on the next edge, `locked` drops, and `data_out` holds its value.
- Reset asserted mid-frame: all registers return to reset values asynchronously. After release, the sequence restarts from IDLE.

## Structure
- Shared `demod_pkg`: state encoding constants and a FRAME_BITS=40 constant.
- One sub-module, `pe_monitor`: absolute value with saturation, threshold compare, and a consecutive-count register. Output is a `pe_loss` level.
- The main FSM, timer, and good/miss counters live in the top module.

## Test plan
Tests use SETTLE_CYC=20, FRAME_WIN=220, SEARCH_TO=800 and all other parameters at default.
1. Reset, `enable`=1 → `dp_rst`=1 for 16 cycles, 20 settle cycles, state=3 at cycle 37, `resync_cnt`=0.
2. Three `valid_flag` pulses 200 cycles apart in SEARCH → `locked`=1 one cycle after the third pulse, with no `data_valid` before it.
3. While locked, `data_in`=40'hCC12345678 plus `valid_flag` → `data_out` equals that value and `data_valid` is high for exactly 1 cycle, one cycle later; `frame_cnt`=1.
4. While locked, stop `valid_flag` → after 440 cycles, state=1, `locked`=0, `resync_cnt`=1.
5. While locked, 40 `sync_flag` pulses with `phase_error`=-32768 → enter RESYNC. The same run with one 100-valued sample at symbol 39 → stays locked.
6. No `valid_flag` in SEARCH for 800 cycles → RESYNC. Dropping `enable` in any state → IDLE next edge with `dp_rst`=1. A `valid_flag` on the same cycle as a miss-loss → no `data_valid`.
